// File: rtl/yon_uretici_pkg.sv
// Shared definitions for the direction sequencer and the catch game core.
// Holds the state encoding, the idle code and the direction code constants.
package yon_uretici_pkg;

    typedef enum logic {
        BOS   = 1'b0,
        OYNAT = 1'b1
    } durum_t;

    localparam logic [3:0] YON_BOS    = 4'b0000;
    localparam logic [3:0] YON_SAG    = 4'b0001;
    localparam logic [3:0] YON_SOL    = 4'b0010;
    localparam logic [3:0] YON_ASAGI  = 4'b0100;
    localparam logic [3:0] YON_YUKARI = 4'b1000;

    // Mirror of a direction: up<->down and left<->right, for reversing a program.
    function automatic logic [3:0] yon_ters(input logic [3:0] yon);
        return {yon[2], yon[3], yon[0], yon[1]};
    endfunction

endpackage

// File: rtl/yon_bellek.sv
// Program store for the direction sequencer: DERINLIK entries of {yon, tekrar},
// one synchronous write port and one asynchronous read port.
module yon_bellek
    import yon_uretici_pkg::*;
#(
    parameter int DERINLIK = 8,
    parameter int TEKRAR_W = 4,
    localparam int AW = $clog2(DERINLIK),
    localparam int VW = 4 + TEKRAR_W
) (
    input  logic          i_clk,
    input  logic          i_yaz_en,
    input  logic [AW-1:0] i_yaz_adr,
    input  logic [VW-1:0] i_yaz_veri,
    input  logic [AW-1:0] i_oku_adr,
    output logic [VW-1:0] o_oku_veri
);

    logic [VW-1:0] r_bellek [DERINLIK];

    // Contents are not reset; the entry count in the top decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_yaz_en) begin
            r_bellek[i_yaz_adr] <= i_yaz_veri;
        end
    end

    assign o_oku_veri = r_bellek[i_oku_adr];

endmodule

// File: rtl/yon_uretici.sv
// Programmable direction-command player: stores a short move program while idle
// and replays it onto the catch core's direction input, once or in a loop.
module yon_uretici
    import yon_uretici_pkg::*;
#(
    parameter int DERINLIK = 8,
    parameter int TEKRAR_W = 4,
    localparam int IW = $clog2(DERINLIK),
    localparam int SW = $clog2(DERINLIK) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_yaz_gecerli,
    input  logic [3:0]          i_yaz_yon,
    input  logic [TEKRAR_W-1:0] i_yaz_tekrar,
    output logic                o_yaz_hazir,
    input  logic                i_temizle,
    input  logic                i_baslat,
    input  logic                i_durdur,
    input  logic                i_dongu,
    output logic [3:0]          o_yon,
    output logic                o_calisiyor,
    output logic                o_bitti,
    output logic [3:0]          o_adim_sayisi,
    output logic [SW-1:0]       o_sayi
);

    localparam logic [SW-1:0] SAYI_MAX = SW'(DERINLIK);

    logic [1:0]          r_rst_senk;
    logic                w_rst_n;

    durum_t              r_durum;
    logic [3:0]          r_yon;
    logic                r_bitti;
    logic [3:0]          r_adim;
    logic [SW-1:0]       r_sayi;
    logic [IW-1:0]       r_indeks;
    logic [TEKRAR_W-1:0] r_tutma;

    durum_t              w_durum_s;
    logic [3:0]          w_yon_s;
    logic                w_bitti_s;
    logic [3:0]          w_adim_s;
    logic [SW-1:0]       w_sayi_s;
    logic [IW-1:0]       w_indeks_s;
    logic [TEKRAR_W-1:0] w_tutma_s;

    logic                w_yaz_hazir;
    logic                w_yaz;
    logic                w_yaz_en;
    logic                w_temizle;
    logic                w_baslat;
    logic                w_son_giris;
    logic [IW-1:0]       w_oku_adr;
    logic [TEKRAR_W+3:0] w_oku_veri;
    logic [3:0]          w_oku_yon;
    logic [TEKRAR_W-1:0] w_oku_tekrar;

    // Reset asserts at once but releases only after two clean clock edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_senk <= 2'b00;
        end else begin
            r_rst_senk <= {r_rst_senk[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_senk[1];

    assign w_yaz_hazir = (r_durum == BOS) && (r_sayi < SAYI_MAX);
    assign w_yaz       = i_yaz_gecerli && w_yaz_hazir;
    assign w_temizle   = (r_durum == BOS) && i_temizle;
    assign w_yaz_en    = w_yaz && !w_temizle;
    assign w_baslat    = (r_durum == BOS) && i_baslat && (r_sayi != '0)
                         && !w_yaz && !i_durdur && !i_temizle;
    assign w_son_giris = ({1'b0, r_indeks} == (r_sayi - SW'(1)));

    // During playback the read port looks one entry ahead; otherwise it points at entry 0.
    assign w_oku_adr = ((r_durum == OYNAT) && !w_son_giris) ? (r_indeks + IW'(1)) : '0;

    yon_bellek #(
        .DERINLIK (DERINLIK),
        .TEKRAR_W (TEKRAR_W)
    ) u_bellek (
        .i_clk      (i_clk),
        .i_yaz_en   (w_yaz_en),
        .i_yaz_adr  (r_sayi[IW-1:0]),
        .i_yaz_veri ({i_yaz_yon, i_yaz_tekrar}),
        .i_oku_adr  (w_oku_adr),
        .o_oku_veri (w_oku_veri)
    );

    assign w_oku_yon    = w_oku_veri[TEKRAR_W+3:TEKRAR_W];
    assign w_oku_tekrar = w_oku_veri[TEKRAR_W-1:0];

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_durum  <= BOS;
            r_yon    <= YON_BOS;
            r_bitti  <= 1'b0;
            r_adim   <= '0;
            r_sayi   <= '0;
            r_indeks <= '0;
            r_tutma  <= '0;
        end else begin
            r_durum  <= w_durum_s;
            r_yon    <= w_yon_s;
            r_bitti  <= w_bitti_s;
            r_adim   <= w_adim_s;
            r_sayi   <= w_sayi_s;
            r_indeks <= w_indeks_s;
            r_tutma  <= w_tutma_s;
        end
    end

    always_comb begin
        w_durum_s  = r_durum;
        w_yon_s    = r_yon;
        w_bitti_s  = 1'b0;
        w_adim_s   = r_adim;
        w_sayi_s   = r_sayi;
        w_indeks_s = r_indeks;
        w_tutma_s  = r_tutma;

        case (r_durum)
            BOS: begin
                if (w_temizle) begin
                    w_sayi_s = '0;
                end else if (w_yaz) begin
                    w_sayi_s = r_sayi + SW'(1);
                end
                if (w_baslat) begin
                    w_durum_s  = OYNAT;
                    w_yon_s    = w_oku_yon;
                    w_tutma_s  = w_oku_tekrar;
                    w_indeks_s = '0;
                    w_adim_s   = '0;
                end
            end
            OYNAT: begin
                // Abort wins over everything, including the last cycle of a pass.
                if (i_durdur) begin
                    w_durum_s = BOS;
                    w_yon_s   = YON_BOS;
                end else if (r_tutma == '0) begin
                    w_adim_s = r_adim + 4'd1;
                    if (w_son_giris && !i_dongu) begin
                        w_durum_s = BOS;
                        w_yon_s   = YON_BOS;
                        w_bitti_s = 1'b1;
                    end else begin
                        w_indeks_s = w_oku_adr;
                        w_yon_s    = w_oku_yon;
                        w_tutma_s  = w_oku_tekrar;
                    end
                end else begin
                    w_tutma_s = r_tutma - TEKRAR_W'(1);
                end
            end
            default: begin
                w_durum_s = BOS;
                w_yon_s   = YON_BOS;
            end
        endcase
    end

    assign o_yaz_hazir   = w_yaz_hazir;
    assign o_yon         = r_yon;
    assign o_calisiyor   = (r_durum == OYNAT);
    assign o_bitti       = r_bitti;
    assign o_adim_sayisi = r_adim;
    assign o_sayi        = r_sayi;

endmodule

// File: tb/tb_yon_uretici.sv
// Bench for yon_uretici: directed scenarios followed by random traffic, compared
// each cycle against a queue-based model of the expected direction stream.
module tb_yon_uretici;
    import yon_uretici_pkg::*;

    localparam int DERINLIK = 8;
    localparam int TEKRAR_W = 4;
    localparam int SW       = $clog2(DERINLIK) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                yaz_gecerli;
    logic [3:0]          yaz_yon;
    logic [TEKRAR_W-1:0] yaz_tekrar;
    logic                yaz_hazir;
    logic                temizle;
    logic                baslat;
    logic                durdur;
    logic                dongu;
    logic [3:0]          yon;
    logic                calisiyor;
    logic                bitti;
    logic [3:0]          adim_sayisi;
    logic [SW-1:0]       sayi;

    always #5 clk = ~clk;

    yon_uretici #(
        .DERINLIK (DERINLIK),
        .TEKRAR_W (TEKRAR_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_yaz_gecerli (yaz_gecerli),
        .i_yaz_yon     (yaz_yon),
        .i_yaz_tekrar  (yaz_tekrar),
        .o_yaz_hazir   (yaz_hazir),
        .i_temizle     (temizle),
        .i_baslat      (baslat),
        .i_durdur      (durdur),
        .i_dongu       (dongu),
        .o_yon         (yon),
        .o_calisiyor   (calisiyor),
        .o_bitti       (bitti),
        .o_adim_sayisi (adim_sayisi),
        .o_sayi        (sayi)
    );

    // Reference model: the stored program, plus the remaining codes of the current
    // pass expanded cycle by cycle, each flagged when it closes an entry.
    logic [3:0]          m_prog_yon [DERINLIK];
    logic [TEKRAR_W-1:0] m_prog_tek [DERINLIK];
    int                  m_sayi;
    bit                  m_play;
    bit                  m_bitti;
    logic [3:0]          m_yon;
    logic [3:0]          m_adim;
    logic [3:0]          q_yon [$];
    bit                  q_son [$];

    int vektor = 0;
    int hata   = 0;

    task automatic kontrol(input string tag, input logic [7:0] gozlenen, input logic [7:0] beklenen);
        vektor++;
        assert (gozlenen === beklenen)
        else begin
            hata++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, gozlenen, beklenen);
        end
    endtask

    task automatic checkOutput();
        kontrol("yon",       {4'b0, yon},         {4'b0, m_yon});
        kontrol("calisiyor", {7'b0, calisiyor},   {7'b0, m_play});
        kontrol("bitti",     {7'b0, bitti},       {7'b0, m_bitti});
        kontrol("adim",      {4'b0, adim_sayisi}, {4'b0, m_adim});
        kontrol("sayi",      8'(sayi),            8'(m_sayi));
        kontrol("yaz_hazir", {7'b0, yaz_hazir},   {7'b0, (!m_play && m_sayi < DERINLIK)});
    endtask

    task automatic modelReset();
        m_sayi  = 0;
        m_play  = 1'b0;
        m_bitti = 1'b0;
        m_yon   = 4'b0000;
        m_adim  = 4'd0;
        q_yon.delete();
        q_son.delete();
    endtask

    task automatic genislet();
        q_yon.delete();
        q_son.delete();
        for (int i = 0; i < m_sayi; i++) begin
            for (int r = 0; r <= int'(m_prog_tek[i]); r++) begin
                q_yon.push_back(m_prog_yon[i]);
                q_son.push_back(r == int'(m_prog_tek[i]));
            end
        end
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit hs;
        bit bas;
        bit son;
        logic [3:0] atilan;
        m_bitti = 1'b0;
        if (!m_play) begin
            hs  = yaz_gecerli && (m_sayi < DERINLIK);
            bas = baslat && (m_sayi > 0) && !hs && !durdur && !temizle;
            if (temizle) begin
                m_sayi = 0;
            end else if (hs) begin
                m_prog_yon[m_sayi] = yaz_yon;
                m_prog_tek[m_sayi] = yaz_tekrar;
                m_sayi++;
            end
            if (bas) begin
                genislet();
                m_play = 1'b1;
                m_adim = 4'd0;
                m_yon  = q_yon[0];
            end
        end else if (durdur) begin
            m_play = 1'b0;
            m_yon  = 4'b0000;
            q_yon.delete();
            q_son.delete();
        end else begin
            atilan = q_yon.pop_front();
            son    = q_son.pop_front();
            if (son) m_adim = m_adim + 4'd1;
            if (q_yon.size() == 0) begin
                if (dongu) begin
                    genislet();
                    m_yon = q_yon[0];
                end else begin
                    m_play  = 1'b0;
                    m_yon   = 4'b0000;
                    m_bitti = 1'b1;
                end
            end else begin
                m_yon = q_yon[0];
            end
            if (atilan === 4'bxxxx) m_yon = 4'bxxxx;
        end
    endtask

    task automatic applyStimulus(input bit g, input logic [3:0] y, input logic [TEKRAR_W-1:0] t,
                                 input bit tem, input bit bas, input bit dur, input bit don);
        yaz_gecerli = g;
        yaz_yon     = y;
        yaz_tekrar  = t;
        temizle     = tem;
        baslat      = bas;
        durdur      = dur;
        dongu       = don;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic bekle(input int n, input bit don);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b0, 1'b0, don);
    endtask

    task automatic ornekProgram();
        applyStimulus(1'b1, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        yaz_gecerli = 1'b0;
        yaz_yon     = 4'b0000;
        yaz_tekrar  = '0;
        temizle     = 1'b0;
        baslat      = 1'b0;
        durdur      = 1'b0;
        dongu       = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;
        bekle(3, 1'b0);

        // Single pass: 0100, 1100, 1100, 0010, then idle with a bitti pulse.
        ornekProgram();
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        bekle(5, 1'b0);
        kontrol("pass_adim", {4'b0, adim_sayisi}, 8'd3);

        // Looping playback of the same program, then abort.
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        bekle(9, 1'b1);
        kontrol("loop_yon", {4'b0, yon}, 8'h0c);
        kontrol("loop_adim", {4'b0, adim_sayisi}, 8'd7);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Fill past capacity; the ninth entry must never be stored.
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'($urandom), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        kontrol("full_sayi", 8'(sayi), 8'd8);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        bekle(10, 1'b0);

        // Start with an empty program is ignored.
        applyStimulus(1'b0, 4'b0000, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        bekle(2, 1'b0);

        // Abort on the second playback cycle, then restart from entry 0.
        ornekProgram();
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        bekle(1, 1'b0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        kontrol("abort_adim", {4'b0, adim_sayisi}, 8'd1);
        bekle(1, 1'b0);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        kontrol("restart_yon", {4'b0, yon}, 8'h04);
        bekle(6, 1'b0);

        // Asynchronous reset between edges during playback.
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        bekle(2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        kontrol("async_yon", {4'b0, yon}, 8'h00);
        kontrol("async_calisiyor", {7'b0, calisiyor}, 8'h00);
        modelReset();
        bekle(2, 1'b0);
        #3;
        rst_n = 1'b1;
        bekle(3, 1'b0);
        applyStimulus(1'b1, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same-cycle conflicts while idle.
        applyStimulus(1'b1, 4'b0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        kontrol("temizle_sayi", 8'(sayi), 8'd0);
        applyStimulus(1'b1, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        kontrol("baslat_yaz", {7'b0, calisiyor}, 8'h00);
        applyStimulus(1'b0, 4'b0000, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        kontrol("baslat_durdur", {7'b0, calisiyor}, 8'h00);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom_range(0, 3)),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
        $finish;
    end

endmodule
